// File: rtl/count_timer_ctrl.sv
// Programmable 32-bit timer: one-shot or periodic terminal-count tick with done flag.
// Optional prescaler enabled by defining TIMER_PRESCALE_EN (adds the presc port).
module count_timer_ctrl #(
   parameter int WIDTH   = 32,
   parameter int PRESC_W = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               stop,
   input  logic               mode,
   input  logic [WIDTH-1:0]   limit,
`ifdef TIMER_PRESCALE_EN
   input  logic [PRESC_W-1:0] presc,
`endif
   output logic [WIDTH-1:0]   count,
   output logic               busy,
   output logic               tick,
   output logic               done
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]         state;
   logic [WIDTH-1:0]   limit_q;
   logic               mode_q;
   logic [PRESC_W-1:0] p_q;
   logic [PRESC_W-1:0] presc_q;
   logic               accept;
   logic               en;

   // A zero limit never starts a run; stop outranks start in the same cycle.
   assign accept = start && !stop && (limit != '0);
   assign en     = (p_q == presc_q);
   assign busy   = (state == S_RUN);

`ifdef TIMER_PRESCALE_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         p_q     <= '0;
         presc_q <= '0;
      end else if (accept) begin
         p_q     <= '0;
         presc_q <= presc;
      end else if (state == S_RUN) begin
         p_q <= en ? '0 : p_q + PRESC_W'(1);
      end
   end
`else
   // Both sides held at zero so every RUN cycle is an enabled cycle.
   assign p_q     = '0;
   assign presc_q = '0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_IDLE;
         count   <= '0;
         tick    <= 1'b0;
         done    <= 1'b0;
         limit_q <= '0;
         mode_q  <= 1'b0;
      end else begin
         tick <= 1'b0;
         if (accept) begin
            limit_q <= limit;
            mode_q  <= mode;
            count   <= '0;
            done    <= 1'b0;
            state   <= S_RUN;
         end else if (stop) begin
            // Count is held; a terminal event in this cycle is discarded.
            state <= S_IDLE;
            done  <= 1'b0;
         end else if (state == S_RUN && en) begin
            if (count == limit_q) begin
               tick <= 1'b1;
               if (mode_q) begin
                  count <= '0;
               end else begin
                  state <= S_DONE;
                  done  <= 1'b1;
               end
            end else begin
               count <= count + WIDTH'(1);
            end
         end
      end
   end

endmodule
